// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter sequencer.
// Holds the FSM state encoding, direction codes and a counter width helper.
package updown_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUp,
    StHoldHi,
    StDown,
    StHoldLo
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: asserts tick_o while the count sits at DIV-1, then wraps.
// clr_i holds the count at zero (used while idle and on abort).
module tick_gen
  import updown_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PreW = cnt_width(DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;

  assign tick_o = (pre_q == PreLast);

  always_comb begin
    pre_d = tick_o ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_sequencer.sv
// Sequences an external up/down counter: load lo, ramp to hi, dwell, ramp back, dwell, repeat.
// Keeps a registered shadow of the counter value and drives all strobes from flops.
module updown_sequencer
  import updown_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned DIV  = 4,
  parameter int unsigned HOLD = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  output logic         cnt_en_o,
  output logic         cnt_dir_o,
  output logic         cnt_load_o,
  output logic [N-1:0] load_val_o,
  output logic [N-1:0] value_o,
  output logic         busy_o,
  output logic         cycle_done_o,
  output logic         err_o
);

  localparam int unsigned HoldW = cnt_width(HOLD);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

  state_e           state_q;
  logic [N-1:0]     lo_r_q, hi_r_q;
  logic [HoldW-1:0] hold_q;
  logic             cnt_en_q, cnt_dir_q, cnt_load_q, busy_q, cycle_done_q, err_q;
  logic [N-1:0]     load_val_q, value_q;
  logic [N-1:0]     val_inc, val_dec;
  logic             tick;
  logic             pre_clr;

  assign val_inc = value_q + 1'b1;
  assign val_dec = value_q - 1'b1;
  assign pre_clr = (state_q == StIdle) || stop_i;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (pre_clr),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      lo_r_q       <= '0;
      hi_r_q       <= '0;
      hold_q       <= '0;
      cnt_en_q     <= 1'b0;
      cnt_dir_q    <= DIR_UP;
      cnt_load_q   <= 1'b0;
      load_val_q   <= '0;
      value_q      <= '0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_en_q     <= 1'b0;
      cnt_load_q   <= 1'b0;
      cycle_done_q <= 1'b0;
      err_q        <= 1'b0;
      // stop outranks start and any coincident tick; harmless when already idle
      if (stop_i) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (lo_i < hi_i) begin
                lo_r_q     <= lo_i;
                hi_r_q     <= hi_i;
                cnt_load_q <= 1'b1;
                load_val_q <= lo_i;
                value_q    <= lo_i;
                cnt_dir_q  <= DIR_UP;
                busy_q     <= 1'b1;
                state_q    <= StUp;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          StUp: begin
            if (tick) begin
              cnt_en_q  <= 1'b1;
              cnt_dir_q <= DIR_UP;
              value_q   <= val_inc;
              if (val_inc == hi_r_q) begin
                hold_q  <= '0;
                state_q <= StHoldHi;
              end
            end
          end
          StDown: begin
            if (tick) begin
              cnt_en_q  <= 1'b1;
              cnt_dir_q <= DIR_DOWN;
              value_q   <= val_dec;
              if (val_dec == lo_r_q) begin
                cycle_done_q <= 1'b1;
                hold_q       <= '0;
                state_q      <= StHoldLo;
              end
            end
          end
          StHoldHi, StHoldLo: begin
            if (tick) begin
              if (hold_q == HoldLast) begin
                hold_q <= '0;
                if (state_q == StHoldHi) begin
                  cnt_dir_q <= DIR_DOWN;
                  state_q   <= StDown;
                end else begin
                  cnt_dir_q <= DIR_UP;
                  state_q   <= StUp;
                end
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cnt_en_o     = cnt_en_q;
  assign cnt_dir_o    = cnt_dir_q;
  assign cnt_load_o   = cnt_load_q;
  assign load_val_o   = load_val_q;
  assign value_o      = value_q;
  assign busy_o       = busy_q;
  assign cycle_done_o = cycle_done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_updown_sequencer.sv
// Directed bench: cycle table for a DIV=2/HOLD=1 instance, plus a DIV=1 ramp and mid-run reset.
module tb_updown_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, DIV=2, HOLD=1
  logic       rst_a, start_a, stop_a;
  logic [3:0] lo_a, hi_a;
  logic       en_a, dir_a, ld_a, busy_a, cd_a, err_a;
  logic [3:0] lv_a, val_a;

  // Instance B: N=4, DIV=1, HOLD=1
  logic       rst_b, start_b, stop_b;
  logic [3:0] lo_b, hi_b;
  logic       en_b, dir_b, ld_b, busy_b, cd_b, err_b;
  logic [3:0] lv_b, val_b;

  updown_sequencer #(.N(4), .DIV(2), .HOLD(1)) u_dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .stop_i(stop_a), .lo_i(lo_a), .hi_i(hi_a),
    .cnt_en_o(en_a), .cnt_dir_o(dir_a), .cnt_load_o(ld_a), .load_val_o(lv_a), .value_o(val_a),
    .busy_o(busy_a), .cycle_done_o(cd_a), .err_o(err_a)
  );

  updown_sequencer #(.N(4), .DIV(1), .HOLD(1)) u_dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start_b), .stop_i(stop_b), .lo_i(lo_b), .hi_i(hi_b),
    .cnt_en_o(en_b), .cnt_dir_o(dir_b), .cnt_load_o(ld_b), .load_val_o(lv_b), .value_o(val_b),
    .busy_o(busy_b), .cycle_done_o(cd_b), .err_o(err_b)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       en;
    logic       dir;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] val;
    logic       busy;
    logic       cd;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int passed = 0;

  task automatic add(input logic s, input logic p, input logic [3:0] l, input logic [3:0] h,
                     input logic en, input logic dir, input logic ld, input logic [3:0] lv,
                     input logic [3:0] val, input logic busy, input logic cd, input logic er);
    vec_t v;
    v.start = s; v.stop = p; v.lo = l; v.hi = h;
    v.en = en; v.dir = dir; v.ld = ld; v.lv = lv; v.val = val;
    v.busy = busy; v.cd = cd; v.err = er;
    vecs.push_back(v);
  endtask

  // Bundle layout: {en, dir, load, busy, cycle_done, err, value[3:0]}
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got en/dir/ld/busy/cd/err=%b value=%0d, want en/dir/ld/busy/cd/err=%b value=%0d",
               name, act[9:4], act[3:0], exp[9:4], exp[3:0]);
    end else begin
      passed++;
    end
  endtask

  task automatic check_lv(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got load_val=%0d, want %0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; stop_a = 1'b0; lo_a = '0; hi_a = '0;
    rst_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; lo_b = '0; hi_b = '0;

    //  start stop lo  hi   en dir ld lv val busy cd err
    add(1, 0, 3, 6,   0, 0, 1, 3, 3, 1, 0, 0);  // load lo
    add(0, 0, 3, 6,   0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 3, 6,   1, 0, 0, 0, 4, 1, 0, 0);
    add(1, 0, 0, 15,  0, 0, 0, 0, 4, 1, 0, 0);  // start + new bounds while busy: ignored
    add(0, 0, 0, 15,  1, 0, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 15,  0, 0, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 15,  1, 0, 0, 0, 6, 1, 0, 0);  // reach hi
    add(0, 0, 0, 15,  0, 0, 0, 0, 6, 1, 0, 0);
    add(0, 0, 0, 15,  0, 1, 0, 0, 6, 1, 0, 0);  // dwell done, dir flips
    add(0, 0, 0, 15,  0, 1, 0, 0, 6, 1, 0, 0);
    add(0, 0, 0, 15,  1, 1, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 15,  0, 1, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 15,  1, 1, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 15,  0, 1, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 15,  1, 1, 0, 0, 3, 1, 1, 0);  // back at lo: cycle_done
    add(0, 0, 0, 15,  0, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 15,  0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 15,  0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 15,  1, 0, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 15,  0, 0, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 15,  1, 0, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 15,  0, 0, 0, 0, 5, 1, 0, 0);
    add(0, 1, 0, 15,  0, 0, 0, 0, 5, 0, 0, 0);  // stop on a tick cycle: no step
    add(0, 0, 0, 15,  0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 1, 3, 6,   0, 0, 0, 0, 5, 0, 0, 0);  // start+stop in idle
    add(0, 0, 3, 6,   0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 0, 9, 9,   0, 0, 0, 0, 5, 0, 0, 1);  // lo == hi rejected
    add(0, 0, 9, 9,   0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 0, 12, 2,  0, 0, 0, 0, 5, 0, 0, 1);  // lo > hi rejected
    add(0, 0, 12, 2,  0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0, 0);  // adjacent bounds
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   1, 1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1,   1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1,   1, 1, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0, 0);

    // Reset held three cycles, then released.
    repeat (3) tick_clk();
    rst_a = 1'b0;
    tick_clk();
    check("reset_a", {en_a, dir_a, ld_a, busy_a, cd_a, err_a, val_a}, 10'b0);
    check_lv("reset_a_lv", lv_a, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start_a = vecs[i].start; stop_a = vecs[i].stop; lo_a = vecs[i].lo; hi_a = vecs[i].hi;
      tick_clk();
      check($sformatf("vec%0d", i), {en_a, dir_a, ld_a, busy_a, cd_a, err_a, val_a},
            {vecs[i].en, vecs[i].dir, vecs[i].ld, vecs[i].busy, vecs[i].cd, vecs[i].err,
             vecs[i].val});
      if (vecs[i].ld) check_lv($sformatf("vec%0d_lv", i), lv_a, vecs[i].lv);
    end
    start_a = 1'b0; stop_a = 1'b0;

    // DIV=1: a step on every ramp cycle, then reset while ramping down.
    rst_b = 1'b0;
    tick_clk();
    check("reset_b", {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b}, 10'b0);
    start_b = 1'b1; lo_b = 4'd2; hi_b = 4'd5;
    tick_clk();
    start_b = 1'b0;
    check("b_load", {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b}, {6'b001100, 4'd2});
    check_lv("b_load_lv", lv_b, 4'd2);
    for (int k = 1; k <= 3; k++) begin
      logic [3:0] expv;
      expv = 4'(2 + k);
      tick_clk();
      check($sformatf("b_up%0d", k), {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b},
            {6'b100100, expv});
    end
    tick_clk();
    check("b_hold", {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b}, {6'b010100, 4'd5});
    tick_clk();
    check("b_down", {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b}, {6'b110100, 4'd4});
    rst_b = 1'b1;
    tick_clk();
    check("b_reset_mid", {en_b, dir_b, ld_b, busy_b, cd_b, err_b, val_b}, 10'b0);
    check_lv("b_reset_mid_lv", lv_b, 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
